// File: rtl/rs15_9_enc.sv
// Systematic RS(15,9) encoder over GF(2^4) (x^4+x+1): echoes 9 message symbols
// on a valid/ready stream, then appends the 6 parity symbols held in an LFSR.
`timescale 1ns/1ps
module rs15_9_enc #(
    parameter int DATA_WIDTH = 4,
    parameter int N          = 15,
    parameter int K          = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_sop,
    output logic                  out_eop,
    output logic                  out_par
);
    localparam int NPAR = N - K;

    // g(x) coefficients g_5..g_0; the leading x^6 term is implicit.
    localparam logic [NPAR-1:0][3:0] GEN = {4'd7, 4'd9, 4'd3, 4'd12, 4'd10, 4'd12};

    typedef enum logic {DATA, PARITY} state_t;

    state_t     state_reg;
    logic [3:0] cnt_reg;
    logic [2:0] pcnt_reg;
    logic [3:0] r_reg      [NPAR];
    logic [3:0] r_div_next [NPAR];
    logic [3:0] r_sh_next  [NPAR];
    logic [3:0] fb;
    logic       free;
    logic       in_xfer;
    logic       par_load;

    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p;
        logic [3:0] x;
        p = 4'd0;
        x = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[2:0], 1'b0} ^ {2'b00, x[3], x[3]};
        end
        return p;
    endfunction

    assign free     = !out_valid | out_ready;
    assign in_ready = (state_reg == DATA) & free;
    assign in_xfer  = in_valid & in_ready;
    assign par_load = (state_reg == PARITY) & free;
    assign fb       = in_data ^ r_reg[NPAR-1];

    generate
        for (genvar gi = 0; gi < NPAR; gi++) begin : g_lfsr
            if (gi == 0) begin : g_first
                assign r_div_next[gi] = gf_mul(fb, GEN[gi]);
                assign r_sh_next[gi]  = 4'd0;
            end else begin : g_rest
                assign r_div_next[gi] = r_reg[gi-1] ^ gf_mul(fb, GEN[gi]);
                assign r_sh_next[gi]  = r_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= DATA;
            cnt_reg   <= 4'd0;
            pcnt_reg  <= 3'd0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_par   <= 1'b0;
            for (int i = 0; i < NPAR; i++) r_reg[i] <= 4'd0;
        end else if (in_xfer) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
            out_sop   <= (cnt_reg == 4'd0);
            out_par   <= 1'b0;
            out_eop   <= 1'b0;
            for (int i = 0; i < NPAR; i++) r_reg[i] <= r_div_next[i];
            if (cnt_reg == 4'(K - 1)) begin
                cnt_reg   <= 4'd0;
                state_reg <= PARITY;
            end else begin
                cnt_reg <= cnt_reg + 4'd1;
            end
        end else if (par_load) begin
            // Shifting zeros in leaves the LFSR clear for the next codeword.
            out_data  <= r_reg[NPAR-1];
            out_valid <= 1'b1;
            out_par   <= 1'b1;
            out_sop   <= 1'b0;
            out_eop   <= (pcnt_reg == 3'(NPAR - 1));
            for (int i = 0; i < NPAR; i++) r_reg[i] <= r_sh_next[i];
            if (pcnt_reg == 3'(NPAR - 1)) begin
                pcnt_reg  <= 3'd0;
                state_reg <= DATA;
            end else begin
                pcnt_reg <= pcnt_reg + 3'd1;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rs15_9_enc.sv
// Directed bench for rs15_9_enc: hand-computed codewords, a long-division
// reference with syndrome checks, stalls, back-to-back words and mid-word reset.
`timescale 1ns/1ps
module tb_rs15_9_enc;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_data = 4'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_data;
    logic       out_sop;
    logic       out_eop;
    logic       out_par;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int ready_mode = 1;   // 0: hold low, 1: hold high, 2: random

    int q_data[$];
    int q_flags[$];
    int q_cyc[$];

    logic [3:0] msg [9];
    logic [3:0] exp_cw [15];
    logic [3:0] cw3 [15] = '{0,0,0,0,0,0,0,0,1, 7,9,3,12,10,12};
    logic [3:0] cw4 [15] = '{0,0,0,0,0,0,0,0,2, 14,1,6,11,7,11};

    rs15_9_enc #(.DATA_WIDTH(4), .N(15), .K(9)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .out_par   (out_par)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            q_data.push_back(int'(out_data));
            q_flags.push_back(int'({out_sop, out_par, out_eop}));
            q_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p = 4'd0;
        logic [3:0] x = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ x;
            x = x[3] ? ({x[2:0], 1'b0} ^ 4'b0011) : {x[2:0], 1'b0};
        end
        return p;
    endfunction

    // Polynomial long division of m(x)*x^6 by g(x).
    task automatic model_encode(input logic [3:0] m [9], output logic [3:0] cw [15]);
        logic [3:0] b  [15];
        logic [3:0] gc [7] = '{1, 7, 9, 3, 12, 10, 12};
        for (int i = 0; i < 15; i++) b[i] = (i < 9) ? m[i] : 4'd0;
        for (int i = 0; i < 9; i++) begin
            logic [3:0] coef = b[i];
            for (int j = 1; j < 7; j++) b[i+j] = b[i+j] ^ gmul(coef, gc[j]);
        end
        for (int i = 0; i < 15; i++) cw[i] = (i < 9) ? m[i] : b[i];
    endtask

    task automatic send_sym(input logic [3:0] d, input bit gaps);
        bit done = 0;
        int budget = 0;
        while (!done) begin
            @(posedge clk); #1;
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = d;
            end
            @(negedge clk);
            if (in_valid && in_ready) done = 1;
            budget++;
            if (!done && budget > 500) begin
                check("send timeout", 32'(budget), 32'd0);
                done = 1;
            end
        end
    endtask

    task automatic send_msg(input bit gaps);
        for (int i = 0; i < 9; i++) send_sym(msg[i], gaps);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_outputs(input int n);
        int budget = 0;
        while (q_data.size() < n && budget < 3000) begin
            @(negedge clk); #1;
            budget++;
        end
        if (q_data.size() < n) check("output timeout", 32'(q_data.size()), 32'(n));
    endtask

    task automatic clear_q();
        q_data.delete();
        q_flags.delete();
        q_cyc.delete();
    endtask

    task automatic check_cw(input string tag, input int base, input logic [3:0] e [15]);
        logic [3:0] rx [15];
        for (int i = 0; i < 15; i++) begin
            int idx = base + i;
            int got_d = (idx < q_data.size()) ? q_data[idx] : -1;
            int got_f = (idx < q_flags.size()) ? q_flags[idx] : -1;
            int exp_f = ((i == 0) ? 4 : 0) + ((i >= 9) ? 2 : 0) + ((i == 14) ? 1 : 0);
            rx[i] = 4'(got_d);
            check($sformatf("%s data[%0d]", tag, i), 32'(got_d), 32'(e[i]));
            check($sformatf("%s flags[%0d]", tag, i), 32'(got_f), 32'(exp_f));
        end
        for (int s = 1; s <= 6; s++) begin
            logic [3:0] a = 4'd1;
            logic [3:0] syn = 4'd0;
            for (int k = 0; k < s; k++) a = gmul(a, 4'd2);
            for (int k = 0; k < 15; k++) syn = gmul(syn, a) ^ rx[k];
            check($sformatf("%s syndrome S%0d", tag, s), 32'(syn), 32'd0);
        end
    endtask

    initial begin
        // T1: reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset flags", 32'({out_sop, out_eop, out_par}), 32'd0);
        check("reset out_data", 32'(out_data), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post-reset in_ready", 32'(in_ready), 32'd1);

        // T2: all-zero message
        clear_q();
        for (int i = 0; i < 9; i++) msg[i] = 4'd0;
        for (int i = 0; i < 15; i++) exp_cw[i] = 4'd0;
        send_msg(1'b0);
        wait_outputs(15);
        check_cw("T2 zero", 0, exp_cw);

        // T3 / T4: single nonzero last symbol
        clear_q();
        for (int i = 0; i < 9; i++) msg[i] = cw3[i];
        send_msg(1'b0);
        wait_outputs(15);
        check_cw("T3 one", 0, cw3);

        clear_q();
        for (int i = 0; i < 9; i++) msg[i] = cw4[i];
        send_msg(1'b0);
        wait_outputs(15);
        check_cw("T4 two", 0, cw4);

        // T5: message 1..9 with input gaps and random backpressure
        clear_q();
        for (int i = 0; i < 9; i++) msg[i] = 4'(i + 1);
        model_encode(msg, exp_cw);
        ready_mode = 2;
        send_msg(1'b1);
        wait_outputs(15);
        ready_mode = 1;
        check_cw("T5 stall", 0, exp_cw);
        repeat (3) @(posedge clk);
        #1;

        // T6: back-to-back codewords
        clear_q();
        for (int i = 0; i < 9; i++) msg[i] = cw3[i];
        send_msg(1'b0);
        for (int i = 0; i < 9; i++) msg[i] = cw4[i];
        send_msg(1'b0);
        wait_outputs(30);
        check_cw("T6 word0", 0, cw3);
        check_cw("T6 word1", 15, cw4);
        check("T6 consecutive span",
              32'((q_cyc.size() >= 30) ? (q_cyc[29] - q_cyc[0]) : -1), 32'd29);

        // T6: reset while parity #3 is presented
        repeat (2) @(posedge clk);
        #1;
        clear_q();
        for (int i = 0; i < 9; i++) msg[i] = cw3[i];
        send_msg(1'b0);
        wait_outputs(12);
        @(posedge clk); #1;
        check("pre-reset parity3 data", 32'(out_data), 32'd12);
        check("pre-reset parity3 par", 32'(out_par), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid-word reset out_valid", 32'(out_valid), 32'd0);
        check("mid-word reset flags", 32'({out_sop, out_eop, out_par}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_q();
        send_msg(1'b0);
        wait_outputs(15);
        check_cw("T6 after reset", 0, cw3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
